// File: rtl/div_arb_pkg.sv
// ---------------------------------------------------------------------------
// div_arb_pkg
//   Shared definitions for the divider arbiter: controller state encoding,
//   divider register addresses, status bit positions and small decode helpers
//   that map a controller state onto the divider bus it drives.
// ---------------------------------------------------------------------------
package div_arb_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_WLS  = 4'd1,
    S_WMS  = 4'd2,
    S_WDEN = 4'd3,
    S_GO   = 4'd4,
    S_WAIT = 4'd5,
    S_RST  = 4'd6,
    S_RREM = 4'd7,
    S_RQUO = 4'd8,
    S_RESP = 4'd9
  } state_t;

  // Divider register map
  localparam logic [1:0] DIV_A_NLS = 2'd0;
  localparam logic [1:0] DIV_A_NMS = 2'd1;
  localparam logic [1:0] DIV_A_DEN = 2'd2;
  localparam logic [1:0] DIV_A_CMD = 2'd3;

  // Status register bit positions
  localparam int ST_DONE = 0;
  localparam int ST_DZ   = 1;
  localparam int ST_OVF  = 2;

  // Divider address presented while in a given state
  function automatic logic [1:0] bus_addr(input state_t s);
    logic [1:0] a;
    case (s)
      S_WLS:   a = DIV_A_NLS;
      S_WMS:   a = DIV_A_NMS;
      S_WDEN:  a = DIV_A_DEN;
      S_GO:    a = DIV_A_CMD;
      S_RST:   a = DIV_A_NLS;
      S_RREM:  a = DIV_A_DEN;
      S_RQUO:  a = DIV_A_CMD;
      default: a = 2'd0;
    endcase
    return a;
  endfunction

  // True for states that perform a divider write
  function automatic logic is_wr_state(input state_t s);
    logic w;
    case (s)
      S_WLS, S_WMS, S_WDEN, S_GO: w = 1'b1;
      default:                    w = 1'b0;
    endcase
    return w;
  endfunction

  // True for states that perform a divider read
  function automatic logic is_rd_state(input state_t s);
    logic r;
    case (s)
      S_RST, S_RREM, S_RQUO: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

  // Successor of a bus-access state once its gap cycle is done
  function automatic state_t bus_next(input state_t s);
    state_t n;
    case (s)
      S_WLS:   n = S_WMS;
      S_WMS:   n = S_WDEN;
      S_WDEN:  n = S_GO;
      S_GO:    n = S_WAIT;
      S_RST:   n = S_RREM;
      S_RREM:  n = S_RQUO;
      S_RQUO:  n = S_RESP;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Starting at ptr and searching upward
//   with wrap-around, the first asserted request wins.
// Ports
//   req    in   N_REQ  pending requests
//   ptr    in   ID_W   highest-priority index for this pick
//   grant  out  N_REQ  one-hot winner (all zero when no request)
//   idx    out  ID_W   index of the winner
//   any    out  1      at least one request is pending
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  localparam int IW = $clog2(N_REQ);

  int          cand;
  logic [IW-1:0] cand_w;

  // Rotating priority search; the first hit at or after ptr wins
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    cand_w = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end else begin
        cand = cand;
      end
      cand_w = IW'(cand);
      if (!any && req[cand_w]) begin
        any           = 1'b1;
        grant[cand_w] = 1'b1;
        idx           = ID_W'(cand);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
//   Shares one divider coprocessor between N_REQ clients. A round-robin pick
//   grants one request, then the controller runs the whole divider bus
//   sequence (write num LS/MS, write den, start, wait irq, read status,
//   remainder, quotient) and returns the result tagged with the client id.
//   Every bus access holds its strobe until div_rdy is sampled high and is
//   followed by one idle gap cycle so the divider's acknowledge can drop.
//
// Optional feature: define DIV_ARB_TIMEOUT_EN to add a watchdog on S_WAIT.
//   After TIMEOUT cycles without irq the quotient is read (returning the
//   divider to idle) and a response with rsp_tmo=1 and zeroed data is sent.
//   Without the macro S_WAIT waits forever and rsp_tmo is tied low.
//
// Ports
//   clk, clr_n         clock, asynchronous active-low reset
//   req_valid/num/den  client requests (num 32b, den 16b per client)
//   req_grant          one-hot accept pulse
//   rsp_valid/id/quo/rem/ovf/dz/tmo   response pulse and held fields
//   busy               high whenever the controller is not idle
//   div_a/rd/wr/dout   divider bus master outputs
//   div_din/rdy/irq    divider read data, acknowledge, done (active low)
// ---------------------------------------------------------------------------
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_num,
  input  logic [16*N_REQ-1:0] req_den,
  output logic [N_REQ-1:0]    req_grant,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_quo,
  output logic [15:0]         rsp_rem,
  output logic                rsp_ovf,
  output logic                rsp_dz,
  output logic                rsp_tmo,
  output logic                busy,
  output logic [1:0]          div_a,
  output logic                div_rd,
  output logic                div_wr,
  output logic [15:0]         div_dout,
  input  logic [15:0]         div_din,
  input  logic                div_rdy,
  input  logic                div_irq
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("div_arbiter: N_REQ must be in 2..8");
  end
  if (ID_W < $clog2(N_REQ)) begin : g_bad_id_w
    $error("div_arbiter: ID_W too narrow for N_REQ");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("div_arbiter: TIMEOUT must be in 1..255");
  end

  state_t            state_r, state_nx;
  logic              gap_r, gap_nx;
  logic [31:0]       num_r, num_nx;
  logic [15:0]       den_r, den_nx;
  logic [ID_W-1:0]   id_r, id_nx;
  logic [ID_W-1:0]   ptr_r, ptr_nx;
  logic [N_REQ-1:0]  grant_nx;
  logic [31:0]       sel_num_s;
  logic [15:0]       sel_den_s;
  logic [15:0]       wr_data_s;

  logic              cap_st_s, cap_rem_s, cap_quo_s;
  logic              ovf_r, dz_r;
  logic [15:0]       rem_r, quo_r;

  logic [N_REQ-1:0]  pick_grant_s;
  logic [ID_W-1:0]   pick_idx_s;
  logic              pick_any_s;

  logic              tmo_hit_s;
  logic              tmo_flag_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

`ifdef DIV_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;
  logic       tmo_flag_r;

  // Watchdog counter: restarts on every entry to S_WAIT
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r != S_WAIT) begin
      tmo_cnt_r <= 8'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end
  end

  assign tmo_hit_s = (tmo_cnt_r == 8'(TIMEOUT));

  // Remembers that the current operation was aborted by the watchdog
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_flag_r <= 1'b0;
    end else if (state_r == S_IDLE) begin
      tmo_flag_r <= 1'b0;
    end else if (state_r == S_WAIT && div_irq && tmo_hit_s) begin
      tmo_flag_r <= 1'b1;
    end else begin
      tmo_flag_r <= tmo_flag_r;
    end
  end

  assign tmo_flag_s = tmo_flag_r;

  // Response timeout flag, loaded with the other response fields
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rsp_tmo <= 1'b0;
    end else if (state_nx == S_RESP) begin
      rsp_tmo <= tmo_flag_r;
    end else begin
      rsp_tmo <= rsp_tmo;
    end
  end
`else
  assign tmo_hit_s  = 1'b0;
  assign tmo_flag_s = 1'b0;
  assign rsp_tmo    = 1'b0;
`endif

  // Next-state logic: arbitration, bus handshake with gap cycle, irq wait
  always_comb begin
    state_nx  = state_r;
    gap_nx    = gap_r;
    num_nx    = num_r;
    den_nx    = den_r;
    id_nx     = id_r;
    ptr_nx    = ptr_r;
    grant_nx  = '0;
    cap_st_s  = 1'b0;
    cap_rem_s = 1'b0;
    cap_quo_s = 1'b0;
    sel_num_s = 32'd0;
    sel_den_s = 16'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant_s[i]) begin
        sel_num_s = req_num[i*32 +: 32];
        sel_den_s = req_den[i*16 +: 16];
      end else begin
        sel_num_s = sel_num_s;
      end
    end
    case (state_r)
      S_IDLE: begin
        if (pick_any_s) begin
          grant_nx = pick_grant_s;
          num_nx   = sel_num_s;
          den_nx   = sel_den_s;
          id_nx    = pick_idx_s;
          if (pick_idx_s == ID_W'(N_REQ - 1)) begin
            ptr_nx = '0;
          end else begin
            ptr_nx = pick_idx_s + ID_W'(1);
          end
          state_nx = S_WLS;
          gap_nx   = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WLS, S_WMS, S_WDEN, S_GO, S_RST, S_RREM, S_RQUO: begin
        if (gap_r) begin
          gap_nx   = 1'b0;
          state_nx = bus_next(state_r);
        end else if (div_rdy) begin
          // Acknowledge seen: capture read data now, idle the bus next cycle
          gap_nx    = 1'b1;
          cap_st_s  = (state_r == S_RST);
          cap_rem_s = (state_r == S_RREM);
          cap_quo_s = (state_r == S_RQUO);
        end else begin
          gap_nx = 1'b0;
        end
      end
      S_WAIT: begin
        if (!div_irq) begin
          state_nx = S_RST;
        end else if (tmo_hit_s) begin
          // Reading the quotient pulls a hung divider back to idle
          state_nx = S_RQUO;
          gap_nx   = 1'b0;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        gap_nx   = 1'b0;
      end
    endcase
  end

  // Write data for the access that starts (or continues) next cycle
  always_comb begin
    wr_data_s = 16'd0;
    if (is_wr_state(state_nx) && !gap_nx) begin
      case (state_nx)
        S_WLS:   wr_data_s = num_nx[15:0];
        S_WMS:   wr_data_s = num_nx[31:16];
        S_WDEN:  wr_data_s = den_nx;
        default: wr_data_s = 16'd0;
      endcase
    end else begin
      wr_data_s = 16'd0;
    end
  end

  // Controller state, operand latches and round-robin pointer
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= S_IDLE;
      gap_r   <= 1'b0;
      num_r   <= 32'd0;
      den_r   <= 16'd0;
      id_r    <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nx;
      gap_r   <= gap_nx;
      num_r   <= num_nx;
      den_r   <= den_nx;
      id_r    <= id_nx;
      ptr_r   <= ptr_nx;
    end
  end

  // Read-data capture on the edge where div_rdy is sampled high
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ovf_r <= 1'b0;
      dz_r  <= 1'b0;
      rem_r <= 16'd0;
      quo_r <= 16'd0;
    end else begin
      if (cap_st_s) begin
        ovf_r <= div_din[ST_OVF];
        dz_r  <= div_din[ST_DZ];
      end else begin
        ovf_r <= ovf_r;
        dz_r  <= dz_r;
      end
      if (cap_rem_s) begin
        rem_r <= div_din;
      end else begin
        rem_r <= rem_r;
      end
      if (cap_quo_s) begin
        quo_r <= div_din;
      end else begin
        quo_r <= quo_r;
      end
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      req_grant <= '0;
      busy      <= 1'b0;
      div_a     <= 2'd0;
      div_rd    <= 1'b0;
      div_wr    <= 1'b0;
      div_dout  <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quo   <= 16'd0;
      rsp_rem   <= 16'd0;
      rsp_ovf   <= 1'b0;
      rsp_dz    <= 1'b0;
    end else begin
      req_grant <= grant_nx;
      busy      <= (state_nx != S_IDLE);
      div_a     <= bus_addr(state_nx);
      div_rd    <= is_rd_state(state_nx) && !gap_nx;
      div_wr    <= is_wr_state(state_nx) && !gap_nx;
      div_dout  <= wr_data_s;
      rsp_valid <= (state_nx == S_RESP);
      if (state_nx == S_RESP) begin
        rsp_id  <= id_r;
        rsp_quo <= tmo_flag_s ? 16'd0 : quo_r;
        rsp_rem <= tmo_flag_s ? 16'd0 : rem_r;
        rsp_ovf <= tmo_flag_s ? 1'b0  : ovf_r;
        rsp_dz  <= tmo_flag_s ? 1'b0  : dz_r;
      end else begin
        rsp_id  <= rsp_id;
        rsp_quo <= rsp_quo;
        rsp_rem <= rsp_rem;
        rsp_ovf <= rsp_ovf;
        rsp_dz  <= rsp_dz;
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
//   Self-checking bench for div_arbiter with a behavioural divider model on
//   the coprocessor bus. Expected grants and responses are queued when a
//   request is driven and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_div_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                clr_n;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_num;
  logic [16*N_REQ-1:0] req_den;
  logic [N_REQ-1:0]    req_grant;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_quo, rsp_rem;
  logic                rsp_ovf, rsp_dz, rsp_tmo, busy;
  logic [1:0]          div_a;
  logic                div_rd, div_wr;
  logic [15:0]         div_dout, div_din;
  logic                div_rdy, div_irq;

  always #5 clk = ~clk;

  div_arbiter #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_den   (req_den),
    .req_grant (req_grant),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_quo   (rsp_quo),
    .rsp_rem   (rsp_rem),
    .rsp_ovf   (rsp_ovf),
    .rsp_dz    (rsp_dz),
    .rsp_tmo   (rsp_tmo),
    .busy      (busy),
    .div_a     (div_a),
    .div_rd    (div_rd),
    .div_wr    (div_wr),
    .div_dout  (div_dout),
    .div_din   (div_din),
    .div_rdy   (div_rdy),
    .div_irq   (div_irq)
  );

  // ---------------- divider model ----------------
  logic [15:0] m_nls, m_nms, m_den, m_quo, m_rem;
  logic [2:0]  m_st;
  logic        m_irq_n;
  int          m_cnt;
  int          hold;
  int          ws;
  logic        stub_irq;

  function automatic logic [33:0] div_model(input logic [15:0] hi, input logic [15:0] lo,
                                            input logic [15:0] d);
    logic [31:0] n;
    logic        dz, ovf;
    logic [15:0] q, r;
    n   = {hi, lo};
    dz  = (d == 16'd0);
    ovf = (hi >= d);
    if (dz || ovf) begin
      q = 16'hFFFF;
      r = 16'hFFFF;
    end else begin
      q = 16'(n / {16'd0, d});
      r = 16'(n % {16'd0, d});
    end
    return {ovf, dz, q, r};
  endfunction

  assign div_rdy = (div_rd | div_wr) && (hold >= ws);
  assign div_irq = m_irq_n | stub_irq;
  assign div_din = !div_rd ? 16'd0 :
                   (div_a == 2'd0) ? {13'd0, m_st} :
                   (div_a == 2'd2) ? m_rem :
                   (div_a == 2'd3) ? m_quo : 16'd0;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_nls <= 16'd0; m_nms <= 16'd0; m_den <= 16'd0;
      m_quo <= 16'd0; m_rem <= 16'd0; m_st <= 3'd0;
      m_irq_n <= 1'b1; m_cnt <= 0; hold <= 0;
    end else begin
      if ((div_rd | div_wr) && !div_rdy) hold <= hold + 1;
      else hold <= 0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_irq_n <= 1'b0;
          m_st[0] <= 1'b1;
        end
      end
      if (div_wr && div_rdy) begin
        case (div_a)
          2'd0: m_nls <= div_dout;
          2'd1: m_nms <= div_dout;
          2'd2: m_den <= div_dout;
          default: begin
            {m_st[2], m_st[1], m_quo, m_rem} <= div_model(m_nms, m_nls, m_den);
            m_st[0] <= 1'b0;
            m_cnt   <= 4;
          end
        endcase
      end
      if (div_rd && div_rdy && div_a == 2'd3) begin
        m_irq_n <= 1'b1;
        m_cnt   <= 0;
        m_st    <= 3'd0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    logic [15:0] quo;
    logic [15:0] rem;
    logic        ovf;
    logic        dz;
    logic        tmo;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] num;
    logic [15:0] den;
    int          ws;
    exp_t        e;
  } vec_t;

  exp_t rsp_q[$];
  int   gnt_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0, go_cyc = -1, rdq_cyc = -1, rsp_cyc = -1;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_packed();
    return 64'({req_grant, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_ovf, rsp_dz,
                rsp_tmo, busy, div_a, div_rd, div_wr, div_dout});
  endfunction

  task automatic run_cycle();
    exp_t e;
    int   g;
    @(negedge clk);
    cyc++;
    if (div_wr && div_a == 2'd3) go_cyc = cyc;
    if (div_rd && div_a == 2'd3) rdq_cyc = cyc;
    if (req_grant != '0) begin
      if (gnt_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL grant_unexpected: got %b expected none", req_grant);
      end else begin
        g = gnt_q.pop_front();
        check("grant", 64'(req_grant), 64'(4'b0001 << g));
        req_valid = req_valid & ~req_grant;
      end
    end
    if (rsp_valid) begin
      rsp_cyc = cyc;
      if (rsp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected none", rsp_id);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_id",  64'(rsp_id),  64'(e.id));
        check("rsp_quo", 64'(rsp_quo), 64'(e.quo));
        check("rsp_rem", 64'(rsp_rem), 64'(e.rem));
        check("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
        check("rsp_dz",  64'(rsp_dz),  64'(e.dz));
        check("rsp_tmo", 64'(rsp_tmo), 64'(e.tmo));
      end
    end
  endtask

  task automatic issue(input int id, input logic [31:0] num, input logic [15:0] den, input exp_t e);
    req_num[id*32 +: 32] = num;
    req_den[id*16 +: 16] = den;
    req_valid[id]        = 1'b1;
    rsp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while (i < budget && !(rsp_q.size() == 0 && gnt_q.size() == 0 && !busy && req_valid == '0)) begin
      run_cycle();
      i++;
    end
    if (i >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d responses outstanding after %0d cycles expected 0",
               name, rsp_q.size(), budget);
      rsp_q.delete();
      gnt_q.delete();
    end
  endtask

  function automatic exp_t mk(input int id, input logic [15:0] q, input logic [15:0] r,
                              input logic ovf, input logic dz, input logic tmo);
    exp_t e;
    e.id = id; e.quo = q; e.rem = r; e.ovf = ovf; e.dz = dz; e.tmo = tmo;
    return e;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    clr_n = 1'b0; req_valid = '0; req_num = '0; req_den = '0;
    ws = 0; stub_irq = 1'b0;

    vecs[0] = '{id: 0, num: 32'd100,        den: 16'd7,      ws: 0, e: mk(0, 16'd14,    16'd2,     1'b0, 1'b0, 1'b0)};
    vecs[1] = '{id: 1, num: 32'h0001_0000,  den: 16'd1,      ws: 1, e: mk(1, 16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 1'b0)};
    vecs[2] = '{id: 2, num: 32'h0000_1234,  den: 16'd0,      ws: 0, e: mk(2, 16'hFFFF,  16'hFFFF,  1'b1, 1'b1, 1'b0)};
    vecs[3] = '{id: 3, num: 32'd40,         den: 16'd8,      ws: 2, e: mk(3, 16'd5,     16'd0,     1'b0, 1'b0, 1'b0)};
    vecs[4] = '{id: 1, num: 32'h000F_FFFF,  den: 16'd16,     ws: 0, e: mk(1, 16'hFFFF,  16'h000F,  1'b0, 1'b0, 1'b0)};
    vecs[5] = '{id: 0, num: 32'h8000_0000,  den: 16'hFFFF,   ws: 3, e: mk(0, 16'h8000,  16'h8000,  1'b0, 1'b0, 1'b0)};
    vecs[6] = '{id: 2, num: 32'h00FF_0000,  den: 16'h00FF,   ws: 0, e: mk(2, 16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 1'b0)};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs_packed(), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // All four clients at once from pointer 0: grants 0,1,2,3
    for (int i = 0; i < N_REQ; i++) gnt_q.push_back(i);
    issue(0, 32'd100, 16'd3, mk(0, 16'd33, 16'd1, 1'b0, 1'b0, 1'b0));
    issue(1, 32'd110, 16'd4, mk(1, 16'd27, 16'd2, 1'b0, 1'b0, 1'b0));
    issue(2, 32'd120, 16'd5, mk(2, 16'd24, 16'd0, 1'b0, 1'b0, 1'b0));
    issue(3, 32'd130, 16'd6, mk(3, 16'd21, 16'd4, 1'b0, 1'b0, 1'b0));
    drain("rr_all", 600);

    // Client 1 alone after the wrap, then all four again: order 2,3,0,1
    gnt_q.push_back(1);
    issue(1, 32'd110, 16'd4, mk(1, 16'd27, 16'd2, 1'b0, 1'b0, 1'b0));
    drain("rr_one", 300);
    gnt_q.push_back(2); gnt_q.push_back(3); gnt_q.push_back(0); gnt_q.push_back(1);
    issue(2, 32'd120, 16'd5, mk(2, 16'd24, 16'd0, 1'b0, 1'b0, 1'b0));
    issue(3, 32'd130, 16'd6, mk(3, 16'd21, 16'd4, 1'b0, 1'b0, 1'b0));
    issue(0, 32'd100, 16'd3, mk(0, 16'd33, 16'd1, 1'b0, 1'b0, 1'b0));
    issue(1, 32'd110, 16'd4, mk(1, 16'd27, 16'd2, 1'b0, 1'b0, 1'b0));
    drain("rr_wrap", 600);

    // Table of single-client divisions, including overflow and divide by zero
    for (int v = 0; v < 7; v++) begin
      ws = vecs[v].ws;
      gnt_q.push_back(vecs[v].id);
      issue(vecs[v].id, vecs[v].num, vecs[v].den, vecs[v].e);
      drain("vec", 400);
      check("idle_after", 64'(busy), 64'd0);
      run_cycle();
      check("rsp_hold", 64'(rsp_quo), 64'(vecs[v].e.quo));
    end
    ws = 0;

    // Reset while parked in S_WAIT: no response, everything back to zero
    stub_irq = 1'b1;
    go_cyc   = -1;
    gnt_q.push_back(0);
    req_num[31:0] = 32'd500; req_den[15:0] = 16'd9; req_valid[0] = 1'b1;
    for (int k = 0; k < 200 && go_cyc < 0; k++) run_cycle();
    check("reached_wait", 64'(go_cyc >= 0), 64'd1);
    repeat (5) run_cycle();
    clr_n = 1'b0;
    #1;
    check("midreset_outs", outs_packed(), 64'd0);
    repeat (4) run_cycle();
    check("midreset_busy", 64'(busy), 64'd0);
    stub_irq = 1'b0;
    clr_n    = 1'b1;
    gnt_q.push_back(2);
    issue(2, 32'd77, 16'd7, mk(2, 16'd11, 16'd0, 1'b0, 1'b0, 1'b0));
    drain("after_reset", 300);

`ifdef DIV_ARB_TIMEOUT_EN
    // Watchdog: irq never arrives, quotient read aborts, tmo response
    stub_irq = 1'b1;
    go_cyc = -1; rdq_cyc = -1; rsp_cyc = -1;
    gnt_q.push_back(1);
    issue(1, 32'd1000, 16'd3, mk(1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1));
    drain("tmo", 300);
    check("tmo_rsp_lat", 64'(rsp_cyc - go_cyc), 64'd13);
    check("tmo_rdq_lat", 64'(rdq_cyc - go_cyc), 64'd11);
    stub_irq = 1'b0;
    gnt_q.push_back(3);
    issue(3, 32'd1000, 16'd3, mk(3, 16'd333, 16'd1, 1'b0, 1'b0, 1'b0));
    drain("tmo_recover", 300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
